// File: rtl/stream_boxcar_decimator_pkg.sv
// Shared definitions for the stream boxcar decimator: default widths,
// derived accumulator width, controller state encoding and the exponent
// clamp helper.
package stream_decim_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int MAX_LOG2_DEF = 10;
  localparam int ACC_W        = DATA_W_DEF + MAX_LOG2_DEF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } decim_state_t;

  // Requested exponents above the supported maximum collapse to the maximum.
  function automatic logic [3:0] clamp_log2(input logic [3:0] req, input logic [3:0] max_log2);
    if (req > max_log2) begin
      return max_log2;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/stream_boxcar_decimator_if.sv
// Sample-in / average-out bundle of the stream boxcar decimator.
// The slave side is the decimator; the master side feeds samples and
// consumes averaged results.
interface stream_boxcar_decimator_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_W-1:0]             stream_in;
  logic                          in_valid;
  logic [DATA_W-1:0]             out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;

  modport slave (
    input  stream_in,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output fifo_level,
    output overflow
  );

  modport master (
    output stream_in,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  fifo_level,
    input  overflow
  );
endinterface

// File: rtl/stream_boxcar_decimator_fifo.sv
// Synchronous FIFO with a registered head word. The head register is
// reloaded every edge from the location the read pointer will point at,
// bypassing the write data when that location is being written, so a push
// into an empty FIFO is visible one edge later.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_next;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == {(AW+1){1'b0}});
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  // Read pointer after this edge, used to prefetch the next head word.
  always_comb begin
    w_rd_next = r_rd_ptr;
    if (w_pop) begin
      w_rd_next = r_rd_ptr + AW'(1'b1);
    end else begin
      w_rd_next = r_rd_ptr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      end
      r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1'b1);
        2'b01:   r_count <= r_count - (AW+1)'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Head word register with write-through bypass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= {WIDTH{1'b0}};
    end else if (w_push && (r_wr_ptr == w_rd_next)) begin
      r_head <= i_wdata;
    end else begin
      r_head <= r_mem[w_rd_next];
    end
  end

  assign o_rdata = r_head;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_count;
endmodule

// File: rtl/stream_boxcar_decimator.sv
// Boxcar decimator: sums non-overlapping blocks of 2^d_lat signed samples,
// divides by arithmetic shift and queues the averages in an output FIFO.
// Pipeline: completing sample -> block sum register -> shifted result
// register -> FIFO push, so a result reaches out_valid two edges after the
// edge that accepted its last sample.
// Optional build macro STREAM_DECIM_ROUND_EN adds 2^(d_lat-1) before the
// shift (round half up) and widens the sum by one bit.
module stream_boxcar_decimator
  import stream_decim_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_LOG2   = MAX_LOG2_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [3:0]                dec_log2,
  stream_boxcar_decimator_if.slave  bus
);
`ifdef STREAM_DECIM_ROUND_EN
  localparam int SUM_W = DATA_W + MAX_LOG2 + 1;
`else
  localparam int SUM_W = DATA_W + MAX_LOG2;
`endif
  localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  decim_state_t              r_state;
  decim_state_t              w_state_nxt;
  logic signed [SUM_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic [3:0]                r_d_lat;
  logic [3:0]                w_dec_clamp;
  logic [CNT_W-1:0]          w_cnt_max;
  logic signed [SUM_W-1:0]   w_in_ext;
  logic signed [SUM_W-1:0]   w_sum;
  logic                      w_blk_done;
  logic                      w_start;
  logic signed [SUM_W-1:0]   r_blk_sum;
  logic [3:0]                r_blk_sh;
  logic                      r_blk_vld;
  logic signed [SUM_W-1:0]   w_bias;
  logic signed [SUM_W-1:0]   w_biased;
  logic [DATA_W-1:0]         r_res;
  logic                      r_res_vld;
  logic                      r_overflow;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_pop;
  logic                      w_drop;
  logic [DATA_W-1:0]         w_head;
  logic [LVL_W-1:0]          w_level;

  assign w_dec_clamp = clamp_log2(dec_log2, 4'(MAX_LOG2));
  assign w_cnt_max   = ~({CNT_W{1'b1}} << r_d_lat);
  assign w_in_ext    = {{(SUM_W-DATA_W){bus.stream_in[DATA_W-1]}}, bus.stream_in};
  assign w_sum       = r_acc + w_in_ext;
  assign w_start     = (r_state == IDLE) && enable;
  assign w_blk_done  = (r_state == ACCUM) && enable && bus.in_valid && (r_cnt == w_cnt_max);
  assign w_pop       = bus.out_ready & ~w_fifo_empty;
  assign w_drop      = r_res_vld & w_fifo_full & ~w_pop;

  // Controller state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enable starts accumulation, dropping enable returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator, sample counter and per-block exponent latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= {SUM_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_d_lat <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_acc   <= {SUM_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_d_lat <= w_dec_clamp;
          end
        end
        ACCUM: begin
          if (!enable) begin
            r_acc <= {SUM_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
          end else if (w_blk_done) begin
            r_acc   <= {SUM_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_d_lat <= w_dec_clamp;
          end else if (bus.in_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1'b1);
          end
        end
        default: begin
          r_acc <= {SUM_W{1'b0}};
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Capture the completed block sum and the exponent it was built with.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blk_sum <= {SUM_W{1'b0}};
      r_blk_sh  <= 4'd0;
      r_blk_vld <= 1'b0;
    end else begin
      r_blk_vld <= w_blk_done;
      if (w_blk_done) begin
        r_blk_sum <= w_sum;
        r_blk_sh  <= r_d_lat;
      end
    end
  end

`ifdef STREAM_DECIM_ROUND_EN
  // Half-LSB bias of the shifted result; none when passing samples through.
  always_comb begin
    w_bias = {SUM_W{1'b0}};
    if (r_blk_sh == 4'd0) begin
      w_bias = {SUM_W{1'b0}};
    end else begin
      w_bias = {{(SUM_W-1){1'b0}}, 1'b1} << (r_blk_sh - 4'd1);
    end
  end
`else
  assign w_bias = {SUM_W{1'b0}};
`endif
  assign w_biased = r_blk_sum + w_bias;

  // Divide by the block length; the mean always fits in DATA_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_res     <= {DATA_W{1'b0}};
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= r_blk_vld;
      if (r_blk_vld) begin
        r_res <= DATA_W'(w_biased >>> r_blk_sh);
      end
    end
  end

  // Sticky drop flag, cleared when a new run starts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_start) begin
      r_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (r_res_vld),
    .i_pop   (bus.out_ready),
    .i_wdata (r_res),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  assign bus.out_data   = w_head;
  assign bus.out_valid  = ~w_fifo_empty;
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_stream_boxcar_decimator.sv
// Bench for stream_boxcar_decimator: table of averaging vectors, a
// scoreboard queue checked whenever the consumer pops, and hand sequences
// for latency, overflow, enable drop, extremes and reset.
module tb_stream_boxcar_decimator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] dec_log2;
  int         checks = 0;
  int         errors = 0;
  int         k;
  logic [31:0] sb[$];

  typedef struct packed {
    logic [3:0]       dlog2;
    logic             gaps;
    logic [0:7][31:0] smp;
    logic [0:7][31:0] expv;
  } vec_t;

  vec_t tbl [4];

  stream_boxcar_decimator_if #(.DATA_W(32), .FIFO_DEPTH(16)) bus ();

  stream_boxcar_decimator #(
    .DATA_W     (32),
    .MAX_LOG2   (10),
    .FIFO_DEPTH (16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .dec_log2 (dec_log2),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard: every pop the consumer takes must match the oldest expected result.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got 0x%08h, expected no output", bus.out_data);
      end else begin
        chk("sb_data", bus.out_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] s, input logic v);
    bus.stream_in = s;
    bus.in_valid  = v;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic restart(input logic [3:0] d);
    enable = 1'b0;
    tick();
    dec_log2 = d;
    enable   = 1'b1;
    tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && bus.out_valid == 1'b0) break;
      tick();
    end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_data"}, bus.out_data, 32'd0);
  endtask

  initial begin
    tbl[0].dlog2 = 4'd2;
    tbl[0].gaps  = 1'b0;
    tbl[0].smp   = {32'd1, 32'd2, 32'd3, 32'd6, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFB};
    tbl[1].dlog2 = 4'd3;
    tbl[1].gaps  = 1'b0;
    tbl[1].smp   = {32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd81};
    tbl[1].expv  = {32'd45, 224'd0};
    tbl[2].dlog2 = 4'd1;
    tbl[2].gaps  = 1'b1;
    tbl[2].smp   = {32'hFFFF_FFFF, 32'd0, 32'd5, 32'd6, 32'd7, 32'hFFFF_FFF8, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tbl[3].dlog2 = 4'd0;
    tbl[3].gaps  = 1'b1;
    tbl[3].smp   = {32'd5, 32'hFFFF_FFFD, 32'd0, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
    tbl[3].expv  = tbl[3].smp;
`ifdef STREAM_DECIM_ROUND_EN
    tbl[0].expv  = {32'd3, 32'hFFFF_FFFC, 192'd0};
    tbl[2].expv  = {32'd0, 32'd6, 32'd0, 32'h7FFF_FFFF, 128'd0};
`else
    tbl[0].expv  = {32'd3, 32'hFFFF_FFFB, 192'd0};
    tbl[2].expv  = {32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 128'd0};
`endif

    reset_n       = 1'b0;
    enable        = 1'b0;
    dec_log2      = 4'd0;
    bus.stream_in = 32'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk_zero("por");
    #11;
    reset_n = 1'b1;
    tick();

    // Table: averaging, floor/round, gaps and pass-through.
    for (int t = 0; t < 4; t++) begin
      restart(tbl[t].dlog2);
      bus.out_ready = 1'b1;
      k = 0;
      for (int j = 0; j < 8; j++) begin
        drive(tbl[t].smp[j], 1'b1);
        if (((j + 1) % (1 << tbl[t].dlog2)) == 0) begin
          sb.push_back(tbl[t].expv[k]);
          k++;
        end
        if (t == 0 && (j == 3 || j == 4)) chk("lat_low", 32'(bus.out_valid), 32'd0);
        if (t == 0 && j == 5) chk("lat_rise", 32'(bus.out_valid), 32'd1);
        if (tbl[t].gaps) drive(32'hDEAD_BEEF, 1'b0);
      end
      wait_drain();
    end

    // Overflow: 20 pass-through samples into a stalled 16-entry FIFO.
    restart(4'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(32'(100 + i), 1'b1);
      if (i < 16) sb.push_back(32'(100 + i));
    end
    tick();
    tick();
    tick();
    chk("ovf_level", 32'(bus.fifo_level), 32'd16);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    // Push into a full FIFO on the same edge as a pop: nothing lost.
    dec_log2 = 4'd3;
    drive(32'd999, 1'b1);
    sb.push_back(32'd999);
    tick();
    bus.out_ready = 1'b1;
    tick();
    chk("full_pushpop_level", 32'(bus.fifo_level), 32'd16);
    wait_drain();
    chk("ovf_drained_level", 32'(bus.fifo_level), 32'd0);

    // Enable drop mid-block (d_lat is now 3): partial block discarded.
    for (int i = 0; i < 5; i++) drive(32'(5000 + i), 1'b1);
    enable = 1'b0;
    tick();
    drive(32'd7777, 1'b1);
    drive(32'd7777, 1'b1);
    tick();
    chk("drop_valid", 32'(bus.out_valid), 32'd0);
    chk("drop_level", 32'(bus.fifo_level), 32'd0);
    chk("drop_ovf_kept", 32'(bus.overflow), 32'd1);
    enable = 1'b1;
    tick();
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) drive(32'(i + 1), 1'b1);
`ifdef STREAM_DECIM_ROUND_EN
    sb.push_back(32'd5);
`else
    sb.push_back(32'd4);
`endif
    wait_drain();

    // Extremes at the largest exponent; second block uses a clamped request.
    restart(4'd10);
    for (int i = 0; i < 1024; i++) begin
      drive(32'h7FFF_FFFF, 1'b1);
      if (i == 500) dec_log2 = 4'hF;
    end
    sb.push_back(32'h7FFF_FFFF);
    for (int i = 0; i < 1024; i++) drive(32'h8000_0000, 1'b1);
    sb.push_back(32'h8000_0000);
    wait_drain();

    // Asynchronous reset while the FIFO is full and overflow is set.
    restart(4'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) drive(32'(200 + i), 1'b1);
    tick();
    tick();
    tick();
    chk("pre_rst_level", 32'(bus.fifo_level), 32'd16);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    bus.stream_in = 32'd55;
    bus.in_valid  = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("rst_async");
    sb.delete();
    enable = 1'b0;
    tick();
    tick();
    #3;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) drive(32'(300 + i), 1'b1);
    tick();
    tick();
    chk_zero("rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_boxcar_decimator.md
Name: stream_boxcar_decimator

Overview:
- Consumes the 32-bit signed sample stream produced by the NCO test stage, one sample per clock when `in_valid` is high.
- Averages non-overlapping blocks of 2^`dec_log2` samples (boxcar decimation).
- Queues the averages in a small FIFO and presents them on a valid/ready output, for capture logic or DMA downstream.
- Exists so a slow consumer can view the NCO output without losing samples.

Parameters:
- `DATA_W`, 32: sample and output width, signed two's complement.
- `MAX_LOG2`, 10: largest permitted `dec_log2`; sets accumulator width `ACC_W = DATA_W + MAX_LOG2`.
- `FIFO_DEPTH`, 16: output FIFO entries; must be a power of two, at least 2.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run control; low forces IDLE.
- `dec_log2` in 4: decimation exponent; values above `MAX_LOG2` are clamped to `MAX_LOG2`.
- `stream_in` in `DATA_W`: signed input sample.
- `in_valid` in 1: `stream_in` is valid this cycle; there is no backpressure upstream.
- `out_data` out `DATA_W`: averaged sample at the FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_data` when high together with `out_valid`.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `overflow` out 1: sticky; a block result was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; accumulator = 0; sample counter = 0.
  - FIFO empty, so `out_valid` = 0, `out_data` = 0, `fifo_level` = 0.
  - `overflow` = 0.
- States:
  - IDLE → ACCUM when `enable` = 1.
    - On this transition, latch `dec_log2` (clamped) into `d_lat`.
    - Clear the accumulator and counter.
  - ACCUM:
    - Each cycle with `in_valid` = 1, add sign-extended `stream_in` to the `ACC_W` accumulator and increment the counter.
    - When the counter reaches 2^`d_lat` − 1 and a valid sample arrives, that sample completes the block; the sum including it goes to the push stage.
    - On that same edge, the accumulator and counter restart at 0.
    - Re-latch `d_lat` from `dec_log2` at every block boundary. A mid-block change of `dec_log2` therefore takes effect at the next block.
  - Any state → IDLE on the edge where `enable` = 0.
    - The partial block is discarded.
    - FIFO contents are retained and still drainable.
    - `overflow` clears on the IDLE → ACCUM transition only.
- Arithmetic:
  - result = completed sum arithmetically shifted right by `d_lat` (floor toward −inf), truncated to `DATA_W`.
  - No saturation is needed: the mean of `DATA_W` values always fits in `DATA_W`.
  - `d_lat` = 0 passes samples through, one output per valid input.
- Latency:
  - The result is registered on the edge after the completing sample, then written to the FIFO on the following edge.
  - `out_valid` rises 2 cycles after the edge that accepted the completing sample, when the FIFO was empty.
- FIFO:
  - Registered read data; `out_data` holds the head entry while `out_valid` = 1.
  - A pop occurs on an edge where `out_valid` and `out_ready` are both 1.
  - Push when full with a simultaneous pop: both occur, the level is unchanged, nothing is dropped.
  - Push when full without a pop: the result is dropped and `overflow` is set.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - `out_data` is don't-care when `out_valid` = 0; the bench must not check it then.
- `in_valid` low cycles: the accumulator holds and the counter does not advance. Gaps stretch a block without corrupting it.

Optional Feature:
- Macro: `STREAM_DECIM_ROUND_EN`.
- Defined: add 2^(`d_lat` − 1) to the sum before the shift (round half up). No bias is added when `d_lat` = 0. The accumulator gains 1 bit of headroom for the bias.
- Undefined: pure floor shift as above.

Decomposition:
- Package `stream_decim_pkg`:
  - constants `DATA_W_DEF` and `MAX_LOG2_DEF`;
  - derived `ACC_W`;
  - state enum `decim_state_t {IDLE, ACCUM}`.
- Sub-module `sync_fifo`:
  - parameterised width and depth;
  - ports: push, pop, full, empty, level, registered head output.
  - The top instantiates it once.

Test Plan:
- Reset with no `enable`: assert `reset_n` = 0 mid-stream → all outputs 0 immediately (async), and stay 0 after release until `enable`.
- Averaging: `dec_log2` = 2, `in_valid` = 1, inputs 1,2,3,6,−4,−4,−4,−5 → outputs 3 and −5 (floor of −4.25), each 2 cycles after the 4th/8th sample. With `STREAM_DECIM_ROUND_EN`: outputs 3 and −4.
- Pass-through and gaps: `dec_log2` = 0 with alternating `in_valid` → each valid sample appears unchanged, 2 cycles later, in order.
- Overflow: `dec_log2` = 0, `out_ready` = 0, 20 valid samples → `fifo_level` = 16, `overflow` = 1. Draining yields the first 16 samples in order. `out_ready` = 1 with a simultaneous push when full → no drop.
- Mid-block `enable` drop: `dec_log2` = 3, 5 samples then `enable` = 0 → no output produced, FIFO unchanged. Re-enable → the next output averages only the new 8 samples, and `overflow` is cleared.
- Extremes: `dec_log2` = 10, 1024 samples of 0x7FFFFFFF → output 0x7FFFFFFF. 1024 samples of 0x80000000 → output 0x80000000. No wrap.
